mips_multicycle_control: RTL

Main control unit for the multicycle MIPS core. A Moore state machine that sequences the shared datapath through fetch, decode, execute, memory and writeback: single ALU, single unified instruction/data memory port, instruction register, register file. It decodes the instruction opcode and funct fields held in the instruction register. It drives every mux select and write enable inside `mips_core`, including the `MemWrite` strobe to the dual-port memory's port 0.

---
 rtl/mips_pkg.sv | 48 ++++
 rtl/mips_alu_decoder.sv | 37 +++
 rtl/mips_multicycle_control.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | mips_pkg
// | Opcode, funct, ALU-control and state encodings shared by the multicycle core.
// | Revision: 1.0
// +----------------------------------------------------------------------------
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mips_alu_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | mips_alu_decoder
// | Maps (ALUOp, funct) to the ALU operation code and flags unknown funct values.
// | Revision: 1.0
// +----------------------------------------------------------------------------
module mips_alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_illegal
);

    always_comb begin
        alu_control   = ALU_ADD;
        funct_illegal = 1'b0;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALU_ADD;
                    FUNCT_SUB: alu_control = ALU_SUB;
                    FUNCT_AND: alu_control = ALU_AND;
                    FUNCT_OR:  alu_control = ALU_OR;
                    FUNCT_SLT: alu_control = ALU_SLT;
                    // Unknown funct still executes as an add so writeback is well defined
                    default:   funct_illegal = 1'b1;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_control.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | mips_multicycle_control
// | Moore control FSM sequencing the shared multicycle MIPS datapath.
// | Revision: 1.0
// +----------------------------------------------------------------------------
module mips_multicycle_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t     r_state;
    state_t     w_next;
    state_t     w_cur;
    logic       r_illegal;
    logic       w_op_legal;
    logic       w_set_illegal;
    logic       w_funct_illegal;
    logic [1:0] w_alu_op;
    logic       w_alu_active;
    logic [2:0] w_alu_control;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regwrite;
    logic       w_pcwrite;
    logic       w_branch;

    // Reset shows FETCH decode immediately so an aborted instruction cannot write
    assign w_cur = rst ? S_FETCH : r_state;

    assign w_op_legal = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
                        (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);

    assign w_set_illegal = ((r_state == S_DECODE) && !w_op_legal) ||
                           ((r_state == S_EXECUTE) && w_funct_illegal);

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH: w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEXEC;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    w_next = S_MEMWB;
            S_EXECUTE:  w_next = S_ALUWB;
            S_ADDIEXEC: w_next = S_ADDIWB;
            default:    w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        IorD         = 1'b0;
        w_memwrite   = 1'b0;
        w_irwrite    = 1'b0;
        RegDst       = 1'b0;
        MemtoReg     = 1'b0;
        w_regwrite   = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        w_alu_op     = ALUOP_ADD;
        w_alu_active = 1'b0;
        PCSrc        = 2'b00;
        w_pcwrite    = 1'b0;
        w_branch     = 1'b0;
        case (w_cur)
            S_FETCH: begin
                w_irwrite    = 1'b1;
                ALUSrcB      = 2'b01;
                w_alu_active = 1'b1;
                w_pcwrite    = 1'b1;
            end
            S_DECODE: begin
                ALUSrcB      = 2'b11;
                w_alu_active = 1'b1;
            end
            S_MEMADR, S_ADDIEXEC: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                w_alu_active = 1'b1;
            end
            S_MEMRD: IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg   = 1'b1;
                w_regwrite = 1'b1;
            end
            S_MEMWR: begin
                IorD       = 1'b1;
                w_memwrite = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA      = 1'b1;
                w_alu_op     = ALUOP_FUNCT;
                w_alu_active = 1'b1;
            end
            S_ALUWB: begin
                RegDst     = 1'b1;
                w_regwrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA      = 1'b1;
                w_alu_op     = ALUOP_SUB;
                w_alu_active = 1'b1;
                PCSrc        = 2'b01;
                w_branch     = 1'b1;
            end
            S_ADDIWB: w_regwrite = 1'b1;
            S_JUMP: begin
                PCSrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    mips_alu_decoder u_alu_decoder (
        .alu_op        (w_alu_op),
        .funct         (funct),
        .alu_control   (w_alu_control),
        .funct_illegal (w_funct_illegal)
    );

    assign ALUControl = w_alu_active ? w_alu_control : 3'b000;
    assign MemWrite   = w_memwrite & ~rst;
    assign IRWrite    = w_irwrite & ~rst;
    assign RegWrite   = w_regwrite & ~rst;
    assign PCEn       = (w_pcwrite | (w_branch & zero)) & ~rst;
    assign illegal_op = r_illegal;
    assign state      = w_cur;

endmodule
`default_nettype wire
